// File: rtl/pic_pkg.sv
// Shared constants for the 8259A-style interrupt sequencer.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package pic_pkg;

  // Sequencer FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK1 = 2'd2;
  localparam logic [1:0] ST_ACK2 = 2'd3;

  // EOI command type carried on eoi_specific
  localparam logic EOI_NS = 1'b0;
  localparam logic EOI_SP = 1'b1;

  // Level reported when the request vanished before the first INTA
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Rotate an 8-bit vector right by n: out[p] = v[(p + n) mod 8]
  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w_dbl;
    w_dbl = {v, v} >> n;
    return w_dbl[7:0];
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Picks the highest-priority unmasked request that outranks the in-service level.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_req (irr & ~imr), i_isr, i_lowest (lowest-priority level);
//        o_cand_valid/o_cand_level (winning request), o_isr_top_level (highest ISR bit).
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] i_req,
  input  logic [7:0] i_isr,
  input  logic [2:0] i_lowest,
  output logic       o_cand_valid,
  output logic [2:0] o_cand_level,
  output logic [2:0] o_isr_top_level
);

  // After rotation bit 0 holds the highest-priority level (lowest + 1).
  logic [2:0] w_shift;
  logic [7:0] w_req_rot;
  logic [7:0] w_isr_rot;
  logic [2:0] w_req_pri;
  logic [2:0] w_isr_pri;
  logic       w_req_any;
  logic       w_isr_any;

  assign w_shift   = i_lowest + 3'd1;
  assign w_req_rot = rotr8(i_req, w_shift);
  assign w_isr_rot = rotr8(i_isr, w_shift);

  // Find-first from the top down so the last hit is the lowest index.
  always_comb begin
    w_req_pri = 3'd0;
    w_req_any = 1'b0;
    w_isr_pri = 3'd0;
    w_isr_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_req_pri = 3'(i);
        w_req_any = 1'b1;
      end
      if (w_isr_rot[i]) begin
        w_isr_pri = 3'(i);
        w_isr_any = 1'b1;
      end
    end
  end

  // Strictly higher priority than anything in service (equal level never nests).
  assign o_cand_valid    = w_req_any && (!w_isr_any || (w_req_pri < w_isr_pri));
  // Rotate back: priority index plus shift gives the physical level.
  assign o_cand_level    = w_req_pri + w_shift;
  assign o_isr_top_level = w_isr_pri + w_shift;

endmodule

// File: rtl/interrupt_sequencer.sv
// 8259A control core: IRR/ISR, priority, INT and the two-pulse INTA vector sequence, EOI.
// Latency: irq->irr 1 cycle, irq->int_out 2 cycles, 2nd inta->vector_valid 1 cycle.
// Backpressure: none; inta/eoi are single-cycle strobes, inta in IDLE is ignored.
// Ports: clk/rst (async active-high); irq, imr, icw2_base/base_wr, aeoi, rotate_en,
//        eoi_valid/eoi_specific/eoi_level, inta in; int_out, vector/vector_valid,
//        irr, isr, busy out.
module interrupt_sequencer
  import pic_pkg::*;
#(
  parameter logic [4:0] RESET_BASE = 5'b00000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic [7:0] imr,
  input  logic [4:0] icw2_base,
  input  logic       base_wr,
  input  logic       aeoi,
  input  logic       rotate_en,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       inta,
  output logic       int_out,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic       busy
);

  logic [1:0] r_state;
  logic [7:0] r_irr;
  logic [7:0] r_blk;      // levels acknowledged whose irq has not yet dropped
  logic [7:0] r_isr;
  logic [2:0] r_lowest;
  logic [4:0] r_base;
  logic [2:0] r_level;
  logic       r_spurious;
  logic       r_int;
  logic [7:0] r_vector;
  logic       r_vector_valid;

  logic [1:0] w_state_next;
  logic       w_cand_valid;
  logic [2:0] w_cand_level;
  logic [2:0] w_isr_top_level;
  logic       w_ack1;
  logic       w_ack2;
  logic       w_ns_eoi;
  logic       w_aeoi_do;
  logic [7:0] w_set;
  logic [7:0] w_eoi_clr;
  logic [7:0] w_aeoi_clr;
  logic [7:0] w_isr_next;
  logic [7:0] w_blk_next;

  priority_resolver u_resolver (
    .i_req           (r_irr & ~imr),
    .i_isr           (r_isr),
    .i_lowest        (r_lowest),
    .o_cand_valid    (w_cand_valid),
    .o_cand_level    (w_cand_level),
    .o_isr_top_level (w_isr_top_level)
  );

  assign w_ack1    = (r_state == ST_PEND) && inta;
  assign w_ack2    = (r_state == ST_ACK1) && inta;
  assign w_ns_eoi  = eoi_valid && (eoi_specific == EOI_NS) && (|r_isr);
  assign w_aeoi_do = w_ack2 && aeoi && !r_spurious;

  // A first INTA with no candidate is spurious and leaves ISR alone.
  assign w_set      = (w_ack1 && w_cand_valid) ? (8'd1 << w_cand_level) : 8'd0;
  assign w_aeoi_clr = w_aeoi_do ? (8'd1 << r_level) : 8'd0;

  // EOI looks at the pre-update ISR; specific EOI on an empty bit is harmless.
  always_comb begin
    w_eoi_clr = 8'd0;
    if (eoi_valid) begin
      if (eoi_specific == EOI_SP) begin
        w_eoi_clr = 8'd1 << eoi_level;
      end else if (w_ns_eoi) begin
        w_eoi_clr = 8'd1 << w_isr_top_level;
      end
    end
  end

  // Set is ORed last so an acknowledge beats a clear of the same bit.
  assign w_isr_next = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_set;

  // Block releases as soon as the line drops; a new acknowledge blocks its level.
  assign w_blk_next = (r_blk & irq) | w_set;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_cand_valid) w_state_next = ST_PEND;
      ST_PEND: begin
        if (inta) begin
          w_state_next = ST_ACK1;
        end else if (!w_cand_valid) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACK1: if (inta) w_state_next = ST_ACK2;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_irr          <= 8'd0;
      r_blk          <= 8'd0;
      r_isr          <= 8'd0;
      r_lowest       <= 3'd7;
      r_base         <= RESET_BASE;
      r_level        <= 3'd0;
      r_spurious     <= 1'b0;
      r_int          <= 1'b0;
      r_vector       <= 8'd0;
      r_vector_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_irr          <= irq & ~w_blk_next;
      r_blk          <= w_blk_next;
      r_isr          <= w_isr_next;
      r_int          <= (w_state_next == ST_PEND);
      r_vector_valid <= w_ack2;

      if (base_wr) begin
        r_base <= icw2_base;
      end

      if (w_ack1) begin
        r_level    <= w_cand_valid ? w_cand_level : SPURIOUS_LEVEL;
        r_spurious <= !w_cand_valid;
      end

      if (w_ack2) begin
        r_vector <= {r_base, r_level};
      end

      // AEOI rotation takes precedence over a coincident non-specific EOI.
      if (rotate_en) begin
        if (w_aeoi_do) begin
          r_lowest <= r_level;
        end else if (w_ns_eoi) begin
          r_lowest <= w_isr_top_level;
        end
      end
    end
  end

  assign int_out      = r_int;
  assign vector       = r_vector;
  assign vector_valid = r_vector_valid;
  assign irr          = r_irr;
  assign isr          = r_isr;
  assign busy         = (r_state != ST_IDLE);

endmodule
